// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and
// baud divider helpers used by both the transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable divide-by-DIV counter; bit_tick marks the last cycle of a
// bit period, pre_tick the cycle before it.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = (cnt == LAST);
    assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bits.
// All outputs are registered from the next-state values.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9_600,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_fpga,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TxD,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    state_t     state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       par, par_n;
    logic       txd_n, done_n;
    logic       hs, tick, pre_tick;

    assign hs = tx_valid && (state == S_IDLE);

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk      (clk_fpga),
        .rst_n    (reset_n),
        .restart  (hs),
        .bit_tick (tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        par_n     = par;
        unique case (state)
            S_IDLE: begin
                if (hs) begin
                    state_n   = S_START;
                    shift_n   = tx_data;
                    bit_cnt_n = '0;
                    par_n     = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
                end
            end
            S_START: begin
                if (tick) state_n = S_DATA;
            end
            S_DATA: begin
                if (tick) begin
                    shift_n   = shift >> 1;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick) state_n = S_STOP;
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        state_n   = S_IDLE;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Line level follows the state being entered so TxD is registered.
    always_comb begin
        txd_n = 1'b1;
        unique case (state_n)
            S_START:  txd_n = 1'b0;
            S_DATA:   txd_n = shift_n[0];
            S_PARITY: txd_n = par_n;
            default:  txd_n = 1'b1;
        endcase
        done_n = (state == S_STOP) && (bit_cnt == LAST_STOP) && pre_tick;
    end

    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            par      <= 1'b0;
            TxD      <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            par      <= par_n;
            TxD      <= txd_n;
            tx_ready <= (state_n == S_IDLE);
            tx_busy  <= (state_n != S_IDLE);
            tx_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three parity/stop configurations
// compared against a frame-level waveform model.
module tb_uart_tx;

    localparam int DIV = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0][7:0] data;
    logic [2:0]      valid;
    logic [2:0]      ready;
    logic [2:0]      txd;
    logic [2:0]      busy;
    logic [2:0]      done;

    int checks   = 0;
    int failures = 0;

    int par_cfg[3]  = '{0, 1, 2};
    int stop_cfg[3] = '{1, 2, 1};

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
              .PARITY(0), .STOP_BITS(1)) u0 (
        .clk_fpga(clk), .reset_n(rst_n), .tx_data(data[0]),
        .tx_valid(valid[0]), .tx_ready(ready[0]), .TxD(txd[0]),
        .tx_busy(busy[0]), .tx_done(done[0]));

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
              .PARITY(1), .STOP_BITS(2)) u1 (
        .clk_fpga(clk), .reset_n(rst_n), .tx_data(data[1]),
        .tx_valid(valid[1]), .tx_ready(ready[1]), .TxD(txd[1]),
        .tx_busy(busy[1]), .tx_done(done[1]));

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
              .PARITY(2), .STOP_BITS(1)) u2 (
        .clk_fpga(clk), .reset_n(rst_n), .tx_data(data[2]),
        .tx_valid(valid[2]), .tx_ready(ready[2]), .TxD(txd[2]),
        .tx_busy(busy[2]), .tx_done(done[2]));

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int flen(input int k);
        return (9 + ((par_cfg[k] != 0) ? 1 : 0) + stop_cfg[k]) * DIV;
    endfunction

    // Expected line level for cycles N+1..N+F, bit i = cycle N+1+i.
    function automatic logic [127:0] frame_wave(input int k, input logic [7:0] b);
        logic       q[$];
        logic       p;
        logic [127:0] w;
        q.push_back(1'b0);
        for (int j = 0; j < 8; j++) q.push_back(b[j]);
        if (par_cfg[k] != 0) begin
            p = ^b;
            if (par_cfg[k] == 2) p = ~p;
            q.push_back(p);
        end
        for (int j = 0; j < stop_cfg[k]; j++) q.push_back(1'b1);
        w = '0;
        for (int i = 0; i < q.size() * DIV; i++) w[i] = q[i / DIV];
        return w;
    endfunction

    // Called at a negedge where the model says the DUT is idle; returns
    // at the negedge of cycle N+F+1.
    task automatic send(input int k, input logic [7:0] b, input bit keep);
        logic [127:0] o_txd, o_done, o_busy, o_rdy, mask;
        logic [7:0]   rb;
        int           f;
        f = flen(k);
        chk("idle_ready", 128'(ready[k]), 128'(1));
        chk("idle_busy", 128'(busy[k]), 128'(0));
        chk("idle_txd", 128'(txd[k]), 128'(1));
        data[k]  = b;
        valid[k] = 1'b1;
        @(posedge clk);
        o_txd = '0; o_done = '0; o_busy = '0; o_rdy = '0;
        for (int i = 0; i < f; i++) begin
            @(negedge clk);
            valid[k] = keep;
            data[k]  = 8'($urandom);
            o_txd[i]  = txd[k];
            o_done[i] = done[k];
            o_busy[i] = busy[k];
            o_rdy[i]  = ready[k];
        end
        mask = (128'(1) << f) - 128'(1);
        chk("txd_wave", o_txd, frame_wave(k, b));
        chk("done_pulse", o_done, 128'(1) << (f - 1));
        chk("busy_span", o_busy, mask);
        chk("ready_low", o_rdy, 128'(0));
        for (int j = 0; j < 8; j++) rb[j] = o_txd[(1 + j) * DIV + DIV / 2];
        chk("rx_byte", 128'(rb), 128'(b));
        @(negedge clk);
    endtask

    initial begin
        int  bad;
        bit  keep;
        rst_n = 1'b0;
        valid = '0;
        data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_txd", 128'(txd), 128'(3'b111));
        chk("rst_ready", 128'(ready), 128'(3'b111));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd !== 3'b111 || ready !== 3'b111 || busy !== 3'b000
                || done !== 3'b000) bad++;
        end
        chk("idle_hold", 128'(bad), 128'(0));

        send(0, 8'hA5, 1'b0);
        repeat (2) @(negedge clk);
        send(1, 8'h07, 1'b0);
        send(2, 8'h07, 1'b0);

        send(1, 8'h55, 1'b1);
        send(1, 8'hFF, 1'b0);

        data[0]  = 8'h00;
        valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (34) @(negedge clk);
        chk("pre_rst_txd", 128'(txd[0]), 128'(0));
        #1 rst_n = 1'b0;
        #1;
        chk("async_txd", 128'(txd[0]), 128'(1));
        chk("async_ready", 128'(ready[0]), 128'(1));
        chk("async_busy", 128'(busy[0]), 128'(0));
        chk("async_done", 128'(done[0]), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(0, 8'h3C, 1'b0);

        keep = 1'b0;
        for (int b = 0; b < 256; b++) begin
            keep = (b != 255) && ($urandom_range(0, 1) == 1);
            send(0, 8'(b), keep);
        end
        for (int k = 1; k < 3; k++) begin
            keep = 1'b0;
            for (int n = 0; n < 30; n++) begin
                if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
                keep = (n != 29) && ($urandom_range(0, 1) == 1);
                send(k, 8'($urandom), keep);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
